// File: rtl/coso_sampler_pkg.sv
// ============================================================================
// Module   : coso_sampler_pkg
// Purpose  : Shared state encoding and default counter widths for coso_sampler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package coso_sampler_pkg;

  localparam int unsigned c_CS_CNT_LENGTH   = 16;
  localparam int unsigned c_DROP_CNT_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAITLOW = 2'd2
  } cs_state_e;

endpackage

`default_nettype wire

// File: rtl/coso_sampler_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchroniser into the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/coso_sampler.sv
// ============================================================================
// Module   : coso_sampler
// Purpose  : Measures RO1 beat periods in RO0 cycles and hands each one to the
//            matching controller over a 4-phase request/acknowledge handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module coso_sampler
  import coso_sampler_pkg::*;
#(
  parameter int unsigned CSCntLength   = c_CS_CNT_LENGTH,
  parameter int unsigned DropCntLength = c_DROP_CNT_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ro1,
  input  logic                     CSAck,
  output logic [CSCntLength-1:0]   CSCnt,
  output logic                     CSReq,
  output logic                     CSSat,
  output logic [DropCntLength-1:0] dropCnt
);

  cs_state_e                state_q, state_d;
  logic                     s0_q, s1_q;
  logic                     ack_s;
  logic                     beat_edge;
  logic                     armed_q, armed_d;
  logic [CSCntLength-1:0]   period_q, period_d;
  logic [CSCntLength-1:0]   cs_cnt_q, cs_cnt_d;
  logic                     cs_req_q, cs_req_d;
  logic                     cs_sat_q, cs_sat_d;
  logic [DropCntLength-1:0] drop_q, drop_d;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (CSAck),
    .q_o (ack_s)
  );

  // ro1 is sampled directly; s0 is the first (metastability-exposed) stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= ro1;
      s1_q <= s0_q;
    end
  end

  assign beat_edge = s0_q & ~s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      period_q <= '0;
      cs_cnt_q <= '0;
      cs_req_q <= 1'b0;
      cs_sat_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      period_q <= period_d;
      cs_cnt_q <= cs_cnt_d;
      cs_req_q <= cs_req_d;
      cs_sat_q <= cs_sat_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cs_cnt_d = cs_cnt_q;
    cs_req_d = cs_req_q;
    cs_sat_d = cs_sat_q;
    drop_d   = drop_q;

    // Loading 1 on the edge makes the latched count equal the edge spacing.
    if (beat_edge) begin
      period_d = CSCntLength'(1);
    end else if (&period_q) begin
      period_d = period_q;
    end else begin
      period_d = period_q + CSCntLength'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (beat_edge) begin
          if (armed_q) begin
            state_d  = REQ;
            cs_cnt_d = period_q;
            cs_sat_d = &period_q;
            cs_req_d = 1'b1;
          end else begin
            armed_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d  = WAITLOW;
          cs_req_d = 1'b0;
        end
        if (beat_edge && !(&drop_q)) begin
          drop_d = drop_q + DropCntLength'(1);
        end
      end
      WAITLOW: begin
        // An edge coinciding with the return to IDLE is still a busy edge.
        if (!ack_s) begin
          state_d = IDLE;
        end
        if (beat_edge && !(&drop_q)) begin
          drop_d = drop_q + DropCntLength'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cs_req_d = 1'b0;
      end
    endcase
  end

  assign CSCnt   = cs_cnt_q;
  assign CSReq   = cs_req_q;
  assign CSSat   = cs_sat_q;
  assign dropCnt = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_coso_sampler.sv
// ============================================================================
// Module   : tb_coso_sampler
// Purpose  : Randomised scoreboard bench for coso_sampler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_coso_sampler;

  localparam int CW = 16;
  localparam int DW = 8;
  localparam int SATP = (1 << CW) - 1;
  localparam int SATD = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ro1;
  logic          CSAck;
  logic [CW-1:0] CSCnt;
  logic          CSReq;
  logic          CSSat;
  logic [DW-1:0] dropCnt;

  always #5 clk = ~clk;

  coso_sampler #(
    .CSCntLength   (CW),
    .DropCntLength (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ro1     (ro1),
    .CSAck   (CSAck),
    .CSCnt   (CSCnt),
    .CSReq   (CSReq),
    .CSSat   (CSSat),
    .dropCnt (dropCnt)
  );

  typedef struct {
    int idx;
    int period;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   latch_cnt = 0;
  int   exp_drops = 0;
  int   last_latch_drop = 0;
  bit   chk_range = 1'b0;
  bit   m_armed = 1'b0;
  int   m_prev = 0;
  bit   last_ro1 = 1'b0;
  int   ack_dly = 4;
  int   ack_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every ro1 rising edge (sampled at posedge idx) is a beat; the
  // first after reset only arms; later ones carry the spacing to the previous.
  task automatic drive(input bit v);
    int idx;
    int d;
    @(negedge clk);
    ro1 = v;
    if (v && !last_ro1) begin
      idx = cyc + 1;
      if (!m_armed) begin
        m_armed = 1'b1;
      end else begin
        d = idx - m_prev;
        q.push_back('{idx: idx, period: (d > SATP) ? SATP : d});
      end
      m_prev = idx;
    end
    last_ro1 = v;
  endtask

  task automatic wave(input int p, input int n, input int hi);
    repeat (n) begin
      for (int i = 0; i < p; i++) drive(i < hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst      = 1'b1;
    ro1      = 1'b0;
    last_ro1 = 1'b0;
    m_armed  = 1'b0;
    q.delete();
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Controller model: raise CSAck ack_dly cycles after seeing CSReq, drop it
  // once CSReq falls (or after ack_hold cycles when ack_hold is nonzero).
  initial begin
    int t;
    CSAck = 1'b0;
    forever begin
      @(negedge clk);
      if (CSReq === 1'b1 && !CSAck) begin
        repeat (ack_dly) @(negedge clk);
        CSAck = 1'b1;
        if (ack_hold > 0) repeat (ack_hold) @(negedge clk);
        t = 0;
        while (CSReq !== 1'b0 && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (t >= 200) check("req_drop_timeout", CSReq, 0);
        CSAck = 1'b0;
      end
    end
  end

  // Monitor: on each CSReq rise, the latched beat must be the one detected
  // in the previous cycle; older queued beats were dropped.
  initial begin
    bit      prev_req = 1'b0;
    logic [CW-1:0] prev_cnt = '0;
    bit      prev_sat = 1'b0;
    exp_t    e;
    int      c;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_CSCnt", CSCnt, 0);
        check("rst_CSReq", CSReq, 0);
        check("rst_CSSat", CSSat, 0);
        check("rst_dropCnt", dropCnt, 0);
        exp_drops       = 0;
        last_latch_drop = 0;
      end else if (CSReq === 1'b1 && !prev_req) begin
        c = cyc;
        while (q.size() > 0 && q[0].idx < c - 1) begin
          void'(q.pop_front());
          if (exp_drops < SATD) exp_drops++;
        end
        if (q.size() == 0) begin
          check("latch_edge_idx", -1, c - 1);
        end else begin
          e = q.pop_front();
          check("latch_edge_idx", e.idx, c - 1);
          check("CSCnt", CSCnt, e.period);
          check("CSSat", CSSat, (e.period == SATP) ? 1 : 0);
          check("dropCnt", dropCnt, exp_drops);
        end
        if (chk_range)
          check("drops_per_handshake_2_to_3",
                ((exp_drops - last_latch_drop) >= 2 && (exp_drops - last_latch_drop) <= 3) ? 1 : 0, 1);
        last_latch_drop = exp_drops;
        latch_cnt++;
      end else begin
        check("CSCnt_hold", CSCnt, prev_cnt);
        check("CSSat_hold", CSSat, prev_sat);
      end
      prev_req = (CSReq === 1'b1);
      prev_cnt = CSCnt;
      prev_sat = CSSat;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int p;
    int hi;
    rst = 1'b1;
    ro1 = 1'b0;
    do_reset(4);

    // First edge only arms; second edge 50 cycles later latches 50.
    base = latch_cnt;
    idle(10);
    drive(1'b1);
    for (int i = 1; i < 50; i++) begin
      drive(1'b0);
      check("first_edge_no_req", CSReq, 0);
    end
    drive(1'b1);
    idle(30);
    check("second_edge_latches", latch_cnt - base, 1);
    check("CSCnt_50", CSCnt, 50);

    // Steady period 37, ack after 4 cycles: every beat latched, none dropped.
    ack_dly = 4;
    base = latch_cnt;
    wave(37, 20, 5);
    idle(40);
    check("p37_latches", latch_cnt - base, 20);
    check("p37_dropCnt", dropCnt, 0);

    // Period 10 with CSAck held 25 cycles: 2-3 drops per handshake.
    ack_dly  = 0;
    ack_hold = 25;
    base = latch_cnt;
    wave(10, 3, 5);
    chk_range = 1'b1;
    wave(10, 30, 5);
    chk_range = 1'b0;
    idle(60);
    ack_hold = 0;
    check("p10_latches_ge5", (latch_cnt - base >= 5) ? 1 : 0, 1);

    // Long low stretch saturates the period; next normal period clears CSSat.
    idle(70000);
    drive(1'b1);
    idle(20);
    check("sat_CSCnt", CSCnt, SATP);
    check("sat_CSSat", CSSat, 1);
    wave(20, 3, 10);
    idle(30);
    check("unsat_CSSat", CSSat, 0);

    // Many busy edges: dropCnt stops at all-ones.
    ack_dly  = 0;
    ack_hold = 60;
    wave(3, 400, 1);
    idle(80);
    ack_hold = 0;
    idle(20);
    check("dropCnt_saturated", dropCnt, SATD);

    // Reset while CSReq is high.
    ack_dly = 8;
    idle(5);
    for (int i = 0; i < 400 && CSReq !== 1'b1; i++) drive((i % 20) < 10);
    check("req_seen_before_reset", CSReq, 1);
    do_reset(1);
    check("post_rst_CSReq", CSReq, 0);
    check("post_rst_CSCnt", CSCnt, 0);
    check("post_rst_CSSat", CSSat, 0);
    check("post_rst_dropCnt", dropCnt, 0);
    base = latch_cnt;
    idle(5);
    drive(1'b1);
    idle(19);
    check("post_rst_first_edge_arms", latch_cnt - base, 0);
    drive(1'b1);
    idle(19);
    check("post_rst_second_edge_latches", latch_cnt - base, 1);
    check("post_rst_CSCnt_20", CSCnt, 20);

    // Randomised periods and controller timing.
    base = latch_cnt;
    repeat (60) begin
      p        = $urandom_range(2, 60);
      hi       = $urandom_range(1, p - 1);
      ack_dly  = $urandom_range(0, 8);
      ack_hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      wave(p, 1, hi);
    end
    ack_hold = 0;
    idle(100);
    check("random_latches_seen", (latch_cnt > base) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
